// File: rtl/resteer_ctrl.sv
// Front-end redirect arbiter: picks one redirect per cycle (ROB > BR > D1), offers it
// to fetch until accepted, then stalls fetch for a short drain window.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no redirect pending, fetch runs freely
//   REDIRECT | latched target offered to fetch, waiting for fetch_ready
//   DRAIN    | redirect delivered, fetch stalled while the counter runs out
module resteer_ctrl #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rob_resteer,
    input  logic [XLEN-1:0] rob_target,
    input  logic            br_resteer,
    input  logic [XLEN-1:0] br_target,
    input  logic            d1_resteer,
    input  logic [XLEN-1:0] d1_target,
    input  logic            fetch_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      redirect_src,
    output logic            flush_fe,
    output logic            flush_be,
    output logic            stall_fetch,
    output logic            busy
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_D1   = 2'd1;
    localparam logic [1:0] SRC_BR   = 2'd2;
    localparam logic [1:0] SRC_ROB  = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [2:0]      cnt_q, cnt_n;
    logic [1:0]      src_q, src_n;
    logic [XLEN-1:0] pc_n;

    logic            req_any;
    logic [1:0]      req_src;
    logic [XLEN-1:0] req_tgt;
    logic            preempt;
    logic            latch;

    // Same-cycle arbitration; target bit 0 is cleared here so the latched pc is always aligned.
    always_comb begin
        req_any = 1'b0;
        req_src = SRC_NONE;
        req_tgt = '0;
        if (rob_resteer) begin
            req_any = 1'b1;
            req_src = SRC_ROB;
            req_tgt = rob_target;
        end else if (br_resteer) begin
            req_any = 1'b1;
            req_src = SRC_BR;
            req_tgt = br_target;
        end else if (d1_resteer) begin
            req_any = 1'b1;
            req_src = SRC_D1;
            req_tgt = d1_target;
        end
        req_tgt[0] = 1'b0;
    end

    // src_q keeps the last source through DRAIN so equal-or-older redirects can still preempt.
    assign preempt = req_any && (req_src >= src_q);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        src_n   = src_q;
        pc_n    = redirect_pc;
        latch   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    latch = 1'b1;
                end
            end
            REDIRECT: begin
                if (preempt) begin
                    latch = 1'b1;
                end else if (fetch_ready) begin
                    if (DRAIN_LOAD == 3'd0) begin
                        state_n = IDLE;
                        src_n   = SRC_NONE;
                    end else begin
                        state_n = DRAIN;
                        cnt_n   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (preempt) begin
                    latch = 1'b1;
                end else if (cnt_q <= 3'd1) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                    src_n   = SRC_NONE;
                end else begin
                    cnt_n = cnt_q - 3'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 3'd0;
                src_n   = SRC_NONE;
            end
        endcase

        // A new winner always restarts the redirect, even if it arrived alongside a handshake.
        if (latch) begin
            state_n = REDIRECT;
            cnt_n   = 3'd0;
            src_n   = req_src;
            pc_n    = req_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            src_q          <= SRC_NONE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            redirect_src   <= SRC_NONE;
            flush_fe       <= 1'b0;
            flush_be       <= 1'b0;
            stall_fetch    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_n;
            cnt_q          <= cnt_n;
            src_q          <= src_n;
            redirect_valid <= (state_n == REDIRECT);
            redirect_pc    <= (state_n == REDIRECT) ? pc_n : '0;
            redirect_src   <= (state_n == REDIRECT) ? src_n : SRC_NONE;
            flush_fe       <= latch;
            flush_be       <= latch && (req_src == SRC_ROB);
            stall_fetch    <= (state_n == DRAIN);
            busy           <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_resteer_ctrl.sv
// Directed bench for resteer_ctrl: a cycle-by-cycle vector trace on the default
// configuration plus short sequences for the zero-drain build and stall length.
module tb_resteer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rob_resteer, br_resteer, d1_resteer, fetch_ready;
    logic [31:0] rob_target, br_target, d1_target;

    logic        redirect_valid, flush_fe, flush_be, stall_fetch, busy;
    logic [31:0] redirect_pc;
    logic [1:0]  redirect_src;

    logic        z_valid, z_ffe, z_fbe, z_stall, z_busy;
    logic [31:0] z_pc;
    logic [1:0]  z_src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    resteer_ctrl #(.XLEN(32), .DRAIN_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .rob_resteer(rob_resteer), .rob_target(rob_target),
        .br_resteer(br_resteer), .br_target(br_target),
        .d1_resteer(d1_resteer), .d1_target(d1_target),
        .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_src(redirect_src), .flush_fe(flush_fe), .flush_be(flush_be),
        .stall_fetch(stall_fetch), .busy(busy)
    );

    resteer_ctrl #(.XLEN(32), .DRAIN_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .rob_resteer(rob_resteer), .rob_target(rob_target),
        .br_resteer(br_resteer), .br_target(br_target),
        .d1_resteer(d1_resteer), .d1_target(d1_target),
        .fetch_ready(fetch_ready),
        .redirect_valid(z_valid), .redirect_pc(z_pc),
        .redirect_src(z_src), .flush_fe(z_ffe), .flush_be(z_fbe),
        .stall_fetch(z_stall), .busy(z_busy)
    );

    typedef struct {
        logic        rst_n;
        logic        rob;
        logic [31:0] rob_t;
        logic        br;
        logic [31:0] br_t;
        logic        d1;
        logic [31:0] d1_t;
        logic        fr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [1:0]  e_src;
        logic        e_ffe;
        logic        e_fbe;
        logic        e_stall;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rob, input logic [31:0] robt,
                       input logic br, input logic [31:0] brt,
                       input logic d1, input logic [31:0] d1t, input logic fr,
                       input logic ev, input logic [31:0] epc, input logic [1:0] esrc,
                       input logic effe, input logic efbe, input logic est, input logic ebusy);
        vec_t v;
        v.rst_n = r; v.rob = rob; v.rob_t = robt; v.br = br; v.br_t = brt;
        v.d1 = d1; v.d1_t = d1t; v.fr = fr;
        v.e_valid = ev; v.e_pc = epc; v.e_src = esrc;
        v.e_ffe = effe; v.e_fbe = efbe; v.e_stall = est; v.e_busy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rob, input logic [31:0] robt,
                         input logic br, input logic [31:0] brt,
                         input logic d1, input logic [31:0] d1t, input logic fr);
        @(negedge clk);
        rst = r; rob_resteer = rob; rob_target = robt; br_resteer = br; br_target = brt;
        d1_resteer = d1; d1_target = d1t; fetch_ready = fr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stall_cnt;
        bit done;

        rst = 1'b0; rob_resteer = 1'b0; br_resteer = 1'b0; d1_resteer = 1'b0;
        rob_target = '0; br_target = '0; d1_target = '0; fetch_ready = 1'b0;

        // rst  rob  rob_t   br  br_t    d1  d1_t     fr | valid pc       src ffe fbe stall busy
        add(0, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0,      1, 'h55,   0, 0,      0,   0, 0,      0, 0, 0, 0, 0);
        add(1, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 0, 0);
        add(1, 0, 0,      0, 0,      1, 'h1003, 1,   1, 'h1002, 1, 1, 0, 0, 1);
        add(1, 0, 0,      0, 0,      0, 0,      1,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      0, 0,      1,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      0, 0,      1,   0, 0,      0, 0, 0, 0, 0);
        add(1, 1, 'h300,  1, 'h200,  1, 'h100,  0,   1, 'h300,  3, 1, 1, 0, 1);
        add(1, 0, 0,      0, 0,      0, 0,      1,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 0, 0);
        add(1, 0, 0,      1, 'h500,  0, 0,      0,   1, 'h500,  2, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++)
            add(1, 0, 0,  0, 0,      0, 0,      0,   1, 'h500,  2, 0, 0, 0, 1);
        add(1, 0, 0,      0, 0,      0, 0,      1,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      1, 'h600,  0,   0, 0,      0, 0, 0, 1, 1);
        add(1, 1, 'h400,  0, 0,      0, 0,      0,   1, 'h400,  3, 1, 1, 0, 1);
        add(1, 0, 0,      1, 'h700,  0, 0,      1,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 0, 0);
        add(1, 0, 0,      1, 'h800,  0, 0,      0,   1, 'h800,  2, 1, 0, 0, 1);
        add(1, 1, 'h900,  0, 0,      0, 0,      1,   1, 'h900,  3, 1, 1, 0, 1);
        add(1, 0, 0,      0, 0,      0, 0,      1,   0, 0,      0, 0, 0, 1, 1);
        add(0, 0, 0,      1, 'h55,   0, 0,      0,   0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 0, 0);
        add(1, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 0, 0);
        add(1, 0, 0,      0, 0,      0, 0,      1,   0, 0,      0, 0, 0, 0, 0);
        add(1, 0, 0,      1, 'hA01,  0, 0,      0,   1, 'hA00,  2, 1, 0, 0, 1);
        add(1, 0, 0,      1, 'hB00,  0, 0,      0,   1, 'hB00,  2, 1, 0, 0, 1);
        add(1, 0, 0,      0, 0,      1, 'hC00,  0,   1, 'hB00,  2, 0, 0, 0, 1);
        add(1, 0, 0,      0, 0,      0, 0,      1,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 1, 1);
        add(1, 0, 0,      0, 0,      0, 0,      0,   0, 0,      0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].rob, vecs[i].rob_t, vecs[i].br, vecs[i].br_t,
                  vecs[i].d1, vecs[i].d1_t, vecs[i].fr);
            chk($sformatf("v%0d valid", i), 32'(redirect_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d pc", i),    redirect_pc,          vecs[i].e_pc);
            chk($sformatf("v%0d src", i),   32'(redirect_src),   32'(vecs[i].e_src));
            chk($sformatf("v%0d ffe", i),   32'(flush_fe),       32'(vecs[i].e_ffe));
            chk($sformatf("v%0d fbe", i),   32'(flush_be),       32'(vecs[i].e_fbe));
            chk($sformatf("v%0d stall", i), 32'(stall_fetch),    32'(vecs[i].e_stall));
            chk($sformatf("v%0d busy", i),  32'(busy),           32'(vecs[i].e_busy));
        end

        // Zero-drain build: the handshake goes straight back to IDLE with no stall.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 'h1235, 0);
        chk("z0 valid", 32'(z_valid), 32'd1);
        chk("z0 pc",    z_pc,         32'h1234);
        chk("z0 src",   32'(z_src),   32'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        chk("z1 valid", 32'(z_valid), 32'd0);
        chk("z1 stall", 32'(z_stall), 32'd0);
        chk("z1 busy",  32'(z_busy),  32'd0);
        chk("z1 src",   32'(z_src),   32'd0);

        // Default build: count stall cycles after one delivered ROB redirect.
        drive(1, 1, 'h40, 0, 0, 0, 0, 1);
        chk("s0 fbe", 32'(flush_be), 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        stall_cnt = 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            if (stall_fetch === 1'b1) stall_cnt++;
            if (busy === 1'b0) done = 1'b1;
            else drive(1, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("s1 drain done", 32'(done), 32'd1);
        chk("s1 stall cycles", 32'(stall_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
